seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle restoring integer divider, one quotient bit per clock.
//  Provides DIV/DIVU/REM/REMU results (RV32M semantics) beside the
//  combinational adder datapath. The core stalls on o_busy and captures
//  results on o_valid.
// PARAMETERS
//  DATA_W  32  operand/result width in bits; must be >= 2
// PORTS
//  i_clk        in   1       single clock, rising edge
//  i_rst_n      in   1       asynchronous active-low reset
//  i_start      in   1       request; sampled only in IDLE
//  i_signed     in   1       1: two's-complement operands; 0: unsigned
//  i_dividend   in   DATA_W  dividend, sampled with i_start
//  i_divisor    in   DATA_W  divisor, sampled with i_start
//  o_busy       out  1       high in CALC and DONE
//  o_valid      out  1       one-cycle pulse; results valid
//  o_quotient   out  DATA_W  quotient, held until next accepted start
//  o_remainder  out  DATA_W  remainder, held until next accepted start
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE, o_busy=0, o_valid=0,
//   o_quotient=0, o_remainder=0, counter=0. Deassertion is synchronised
//   by the integrator, not in this block.
//  FSM (Moore outputs): IDLE -> CALC -> DONE -> IDLE.
//   - IDLE & i_start & divisor!=0: latch |dividend|, |divisor| (abs only
//     when i_signed). Latch sign_q = sign(a)^sign(b) and sign_r = sign(a).
//     Clear partial remainder. Set count=DATA_W-1. Go to CALC.
//   - IDLE & i_start & divisor==0: go to DONE with quotient='1 (all
//     ones) and remainder=i_dividend, both signed and unsigned. No CALC.
//   - CALC, each edge: rem_shift={rem[DATA_W-2:0],dvd[MSB]}, dvd<<=1.
//     diff=rem_shift-divisor in DATA_W+1 bits.
//     If diff>=0: rem=diff and the quotient LSB gets 1. Else: rem=rem_shift
//     and the quotient LSB gets 0.
//     When count==0, apply the sign fix and go to DONE; otherwise count--.
//   - Sign fix: quotient negated if sign_q; remainder negated if sign_r.
//   - DONE: o_valid=1 for exactly one cycle. Next edge goes to IDLE.
//  Latency: start edge -> o_valid high DATA_W+1 edges later (normal), or
//   1 edge later (divide by zero). Throughput: a new start is accepted in
//   the cycle after DONE.
//  i_start while o_busy=1: ignored, with no effect on the operation in
//   flight. Operands may change freely after the start edge.
//  Signed overflow (-2^(DATA_W-1) / -1): quotient=-2^(DATA_W-1),
//   remainder=0. This result falls out of the unsigned core plus the sign
//   fix and must not be special-cased incorrectly.
//  abs() of the most negative value stays 2^(DATA_W-1) and is treated as
//   unsigned magnitude.
//  Reset mid-operation: immediate return to IDLE with all outputs cleared.
//   No o_valid is produced for the aborted operation.
//  All arithmetic is modulo 2^DATA_W except diff, which is DATA_W+1 bits
//   wide for the borrow.
// STRUCTURE
//  div_pkg: typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e.
//   The package also holds localparam DIV_W_DEF=32.
//  One sub-module, div_step: combinational single restoring step.
//   Inputs: rem_shift, divisor. Outputs: new_rem, q_bit.
//   Subtraction is implemented as rem_shift + ~divisor + 1.
//  Top level: FSM, counter ($clog2(DATA_W) bits), operand/sign registers,
//   and the abs / negate logic.
// TESTING
//  1. Unsigned: dividend=100, divisor=7, signed=0
//     -> after 33 edges o_valid=1, quotient=14, remainder=2.
//  2. Signed: -100 / 7 -> quotient=-14 (0xFFFFFFF2), remainder=-2
//     (0xFFFFFFFE). Also 100 / -7 -> quotient=-14, remainder=2.
//  3. Divide by zero: 0x12345678 / 0, both signed and unsigned
//     -> o_valid one edge after start, quotient=0xFFFFFFFF,
//     remainder=0x12345678.
//  4. Overflow: 0x80000000 / 0xFFFFFFFF, signed=1
//     -> quotient=0x80000000, remainder=0.
//     With signed=0 -> quotient=0, remainder=0x80000000.
//  5. Start while busy: second i_start with new operands at cycle 5
//     -> ignored. First result is correct, one o_valid pulse only.
//     Back-to-back start right after DONE is accepted.
//  6. Reset at CALC cycle 10 -> outputs all 0, state IDLE, no o_valid.
//     A fresh 0xFFFFFFFF / 1 (unsigned) then gives quotient=0xFFFFFFFF,
//     remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int DIV_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract, keep the difference if it does not borrow.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_shift,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] new_rem,
  output logic              q_bit
);

  logic [DATA_W:0] diff;

  // diff[DATA_W] is the borrow: set when rem_shift < divisor
  always_comb begin
    diff    = {1'b0, rem_shift} + {1'b1, ~divisor} + {{DATA_W{1'b0}}, 1'b1};
    q_bit   = ~diff[DATA_W];
    new_rem = diff[DATA_W] ? rem_shift : diff[DATA_W-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (RV32M DIV/DIVU/REM/REMU), one quotient bit per clock.
module seq_divider
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_busy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

  div_state_e        state;
  div_state_e        state_nxt;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-2:0] rem;
  logic [DATA_W-1:0] dsr;
  logic              sign_q;
  logic              sign_r;

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;
  logic              div_zero;
  logic [DATA_W-1:0] rem_shift;
  logic [DATA_W-1:0] new_rem;
  logic              q_bit;
  logic [DATA_W-1:0] q_next;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  // Operand magnitudes; abs of the most negative value wraps to itself, read as unsigned
  always_comb begin
    a_neg     = i_signed & i_dividend[DATA_W-1];
    b_neg     = i_signed & i_divisor[DATA_W-1];
    a_abs     = a_neg ? (~i_dividend + ONE) : i_dividend;
    b_abs     = b_neg ? (~i_divisor + ONE) : i_divisor;
    div_zero  = (i_divisor == {DATA_W{1'b0}});
    rem_shift = {rem, dvd[DATA_W-1]};
    q_next    = {dvd[DATA_W-2:0], q_bit};
    q_fix     = sign_q ? (~q_next + ONE) : q_next;
    r_fix     = sign_r ? (~new_rem + ONE) : new_rem;
  end

  div_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .rem_shift(rem_shift),
    .divisor  (dsr),
    .new_rem  (new_rem),
    .q_bit    (q_bit)
  );

  // Next-state decode
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = div_zero ? DONE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (count == CNT_ZERO) begin
          state_nxt = DONE;
        end else begin
          state_nxt = CALC;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered Moore outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      count       <= CNT_ZERO;
      dvd         <= {DATA_W{1'b0}};
      rem         <= {(DATA_W-1){1'b0}};
      dsr         <= {DATA_W{1'b0}};
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      o_busy      <= 1'b0;
      o_valid     <= 1'b0;
      o_quotient  <= {DATA_W{1'b0}};
      o_remainder <= {DATA_W{1'b0}};
    end else begin
      state   <= state_nxt;
      o_busy  <= (state_nxt != IDLE);
      o_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (i_start) begin
            if (div_zero) begin
              o_quotient  <= {DATA_W{1'b1}};
              o_remainder <= i_dividend;
            end else begin
              dvd    <= a_abs;
              dsr    <= b_abs;
              rem    <= {(DATA_W-1){1'b0}};
              count  <= CNT_LAST;
              sign_q <= a_neg ^ b_neg;
              sign_r <= a_neg;
            end
          end
        end
        CALC: begin
          dvd <= q_next;
          // Partial remainder stays below 2^(DATA_W-1) until the final step
          rem <= new_rem[DATA_W-2:0];
          if (count == CNT_ZERO) begin
            o_quotient  <= q_fix;
            o_remainder <= r_fix;
          end else begin
            count <= count - CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider with hand-computed results.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic        i_signed;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;

  seq_divider #(.DATA_W(32)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_signed   (i_signed),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_quotient (o_quotient),
    .o_remainder(o_remainder)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid) valid_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the idle cycle after DONE.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input int exp_lat, input bit poke);
    int n;
    int base;
    base       = valid_cnt;
    i_start    = 1'b1;
    i_signed   = sg;
    i_dividend = a;
    i_divisor  = b;
    @(posedge clk);
    n = 1;
    #1;
    i_start    = 1'b0;
    i_signed   = ~sg;
    i_dividend = $urandom;
    i_divisor  = $urandom;
    @(negedge clk);
    while (!o_valid && n < 60) begin
      if (poke && n == 5) begin
        i_start    = 1'b1;
        i_signed   = 1'b0;
        i_dividend = 32'd5;
        i_divisor  = 32'd1;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    i_start = 1'b0;
    check_eq({tag, "_lat"}, n, exp_lat);
    check_eq({tag, "_q"}, o_quotient, exp_q);
    check_eq({tag, "_r"}, o_remainder, exp_r);
    @(negedge clk);
    check_eq({tag, "_pulse"}, o_valid, 1'b0);
    check_eq({tag, "_idle"}, o_busy, 1'b0);
    check_eq({tag, "_nvalid"}, valid_cnt - base, 32'd1);
  endtask

  initial begin
    int base;
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_signed   = 1'b0;
    i_dividend = 32'd0;
    i_divisor  = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", o_busy, 1'b0);
    check_eq("rst_valid", o_valid, 1'b0);
    check_eq("rst_q", o_quotient, 32'd0);
    check_eq("rst_r", o_remainder, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_div("u100_7",   32'd100,      32'd7,          1'b0, 32'd14,       32'd2,        33, 1'b0);
    do_div("sm100_7",  32'hFFFFFF9C, 32'd7,          1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 33, 1'b0);
    do_div("s100_m7",  32'd100,      32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2, 32'd2,        33, 1'b0);
    do_div("sm100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9,   1'b1, 32'd14,       32'hFFFFFFFE, 33, 1'b0);
    do_div("dz_s",     32'h12345678, 32'd0,          1'b1, 32'hFFFFFFFF, 32'h12345678, 1,  1'b0);
    do_div("dz_u",     32'h12345678, 32'd0,          1'b0, 32'hFFFFFFFF, 32'h12345678, 1,  1'b0);
    do_div("ovf_s",    32'h80000000, 32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0,        33, 1'b0);
    do_div("ovf_u",    32'h80000000, 32'hFFFFFFFF,   1'b0, 32'd0,        32'h80000000, 33, 1'b0);
    do_div("busy",     32'd1000,     32'd10,         1'b0, 32'd100,      32'd0,        33, 1'b1);
    do_div("b2b",      32'd45,       32'd6,          1'b0, 32'd7,        32'd3,        33, 1'b0);

    // Abort an operation in flight with reset
    i_start    = 1'b1;
    i_signed   = 1'b0;
    i_dividend = 32'hDEADBEEF;
    i_divisor  = 32'd3;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", o_busy, 1'b0);
    check_eq("abort_valid", o_valid, 1'b0);
    check_eq("abort_q", o_quotient, 32'd0);
    check_eq("abort_r", o_remainder, 32'd0);
    base = valid_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("abort_novalid", valid_cnt - base, 32'd0);
    check_eq("abort_idle", o_busy, 1'b0);

    do_div("post_rst", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 33, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
